// File: rtl/ts_ddr_write_packer.sv
// ts_ddr_write_packer: packs valid TS bytes from the show-ahead input FIFO into 32-bit DDR3 writes
// Define TS_PKT_ALIGN_EN to start every sync byte on a fresh word boundary
module ts_ddr_write_packer #(
   parameter logic [23:0] BASE_ADDR = 24'h000000,
   parameter logic [23:0] LAST_ADDR = 24'hFFFFFF
) (
   input  logic        SYS_CLOCK,
   input  logic        SYS_RESET,
   input  logic        START,
   input  logic        STOP,
   input  logic [9:0]  fifo_q,
   input  logic        fifo_empty,
   output logic        fifo_rdreq,
   output logic [23:0] ddr_write_address,
   output logic        ddr_write_write,
   output logic [31:0] ddr_write_writedata,
   output logic [3:0]  ddr_write_byteenable,
   input  logic        ddr_write_waitrequest,
   output logic        BUSY,
   output logic        DONE,
   output logic        MEM_FULL,
   output logic [23:0] WORDS_WRITTEN
);
   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WRITE, ST_DONE} state_t;
   state_t      state_q, state_d;
   logic [1:0]  lane_q, lane_d, lane_nx;
   logic [31:0] data_q, data_d;
   logic [3:0]  be_q, be_d;
   logic [23:0] addr_q, addr_d;
   logic [23:0] words_q, words_d;
   logic        stop_q, stop_d, full_q, full_d;
   logic        align_hold, byte_in, stop_now;
`ifdef TS_PKT_ALIGN_EN
   assign align_hold = fifo_q[9] && fifo_q[8] && (lane_q != 2'd0) && !fifo_empty;
`else
   logic unused_sync;
   assign unused_sync = fifo_q[8];
   assign align_hold  = 1'b0;
`endif
   assign fifo_rdreq = (state_q == ST_FILL) && !fifo_empty && !align_hold;
   assign byte_in    = fifo_rdreq && fifo_q[9];
   assign lane_nx    = lane_q + {1'b0, byte_in};
   assign stop_now   = stop_q || STOP;
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      data_d  = data_q;
      be_d    = be_q;
      addr_d  = addr_q;
      words_d = words_q;
      stop_d  = stop_q;
      full_d  = full_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               state_d = ST_FILL;
               lane_d  = 2'd0;
               data_d  = 32'h0;
               be_d    = 4'h0;
               addr_d  = BASE_ADDR;
               words_d = 24'h0;
               stop_d  = 1'b0;
               full_d  = 1'b0;
            end
         end
         ST_FILL: begin
            if (byte_in) begin
               data_d[lane_q*8 +: 8] = fifo_q[7:0];
               be_d[lane_q]          = 1'b1;
               lane_d                = lane_nx;
            end
            // a full word or a sync-forced partial word is flushed; STOP rides along
            if (align_hold || (byte_in && lane_q == 2'd3)) begin
               state_d = ST_WRITE;
               lane_d  = 2'd0;
               stop_d  = STOP;
            end else if (STOP) begin
               lane_d  = 2'd0;
               state_d = (lane_nx != 2'd0) ? ST_WRITE : ST_DONE;
               stop_d  = (lane_nx != 2'd0);
            end
         end
         ST_WRITE: begin
            stop_d = stop_now;
            if (!ddr_write_waitrequest) begin
               words_d = (words_q == 24'hFFFFFF) ? words_q : words_q + 24'd1;
               be_d    = 4'h0;
               data_d  = 32'h0;
               stop_d  = 1'b0;
               if (addr_q == LAST_ADDR) begin
                  full_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  addr_d  = addr_q + 24'd1;
                  state_d = stop_now ? ST_DONE : ST_FILL;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge SYS_CLOCK or posedge SYS_RESET) begin
      if (SYS_RESET) begin
         state_q <= ST_IDLE;
         lane_q  <= 2'd0;
         data_q  <= 32'h0;
         be_q    <= 4'h0;
         addr_q  <= 24'h0;
         words_q <= 24'h0;
         stop_q  <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         data_q  <= data_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         words_q <= words_d;
         stop_q  <= stop_d;
         full_q  <= full_d;
      end
   end
   assign ddr_write_address    = addr_q;
   assign ddr_write_write      = (state_q == ST_WRITE);
   assign ddr_write_writedata  = data_q;
   assign ddr_write_byteenable = be_q;
   assign BUSY                 = (state_q == ST_FILL) || (state_q == ST_WRITE);
   assign DONE                 = (state_q == ST_DONE);
   assign MEM_FULL             = full_q;
   assign WORDS_WRITTEN        = words_q;
endmodule

// File: tb/tb_ts_ddr_write_packer.sv
// tb_ts_ddr_write_packer: scoreboard bench with a show-ahead FIFO model per DUT instance
module tb_ts_ddr_write_packer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;
   typedef logic [59:0] wr_t;
   logic [9:0] q0[$], q1[$];
   wr_t sb0[$], sb1[$];
   int n_tests = 0, n_fail = 0;
   logic        start0 = 0, stop0 = 0, wait0 = 0, empty0 = 1, rd0, write0, busy0, done0, full0, pop0 = 0;
   logic [9:0]  fq0 = '0;
   logic [23:0] addr0, words0;
   logic [31:0] data0;
   logic [3:0]  be0;
   logic        start1 = 0, stop1 = 0, wait1 = 0, empty1 = 1, rd1, write1, busy1, done1, full1, pop1 = 0;
   logic [9:0]  fq1 = '0;
   logic [23:0] addr1, words1;
   logic [31:0] data1;
   logic [3:0]  be1;
   ts_ddr_write_packer u0 (
      .SYS_CLOCK(clk), .SYS_RESET(rst), .START(start0), .STOP(stop0),
      .fifo_q(fq0), .fifo_empty(empty0), .fifo_rdreq(rd0),
      .ddr_write_address(addr0), .ddr_write_write(write0), .ddr_write_writedata(data0),
      .ddr_write_byteenable(be0), .ddr_write_waitrequest(wait0),
      .BUSY(busy0), .DONE(done0), .MEM_FULL(full0), .WORDS_WRITTEN(words0));
   ts_ddr_write_packer #(.BASE_ADDR(24'hFFFFFE), .LAST_ADDR(24'hFFFFFF)) u1 (
      .SYS_CLOCK(clk), .SYS_RESET(rst), .START(start1), .STOP(stop1),
      .fifo_q(fq1), .fifo_empty(empty1), .fifo_rdreq(rd1),
      .ddr_write_address(addr1), .ddr_write_write(write1), .ddr_write_writedata(data1),
      .ddr_write_byteenable(be1), .ddr_write_waitrequest(wait1),
      .BUSY(busy1), .DONE(done1), .MEM_FULL(full1), .WORDS_WRITTEN(words1));
   function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endfunction
   // show-ahead FIFO models: pop decided mid-cycle, head refreshed just after the edge
   always @(negedge clk) begin
      pop0 = rd0 && !empty0;
      pop1 = rd1 && !empty1;
   end
   always @(posedge clk) begin
      if (pop0 && q0.size() != 0) void'(q0.pop_front());
      if (pop1 && q1.size() != 0) void'(q1.pop_front());
      #1;
      empty0 = (q0.size() == 0);
      fq0    = empty0 ? 10'h0 : q0[0];
      empty1 = (q1.size() == 0);
      fq1    = empty1 ? 10'h0 : q1[0];
   end
   always @(negedge clk) begin
      if (!rst && write0 && !wait0) begin
         if (sb0.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL u0_unexpected_write: got %h expected none", {addr0, data0, be0});
         end else chk("u0_write", {4'h0, addr0, data0, be0}, {4'h0, sb0.pop_front()});
      end
      if (!rst && write1 && !wait1) begin
         if (sb1.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL u1_unexpected_write: got %h expected none", {addr1, data1, be1});
         end else chk("u1_write", {4'h0, addr1, data1, be1}, {4'h0, sb1.pop_front()});
      end
   end
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   function automatic void pb0(logic [1:0] vs, logic [7:0] b);
      q0.push_back({vs, b});
   endfunction
   function automatic void ex0(logic [23:0] a, logic [31:0] d, logic [3:0] be);
      sb0.push_back({a, d, be});
   endfunction
   task automatic pulse_start0();
      start0 = 1; tick(); start0 = 0;
   endtask
   task automatic wait_empty0(string n);
      for (int i = 0; i < 200 && q0.size() != 0; i++) tick();
      chk(n, 64'(q0.size()), 64'd0);
   endtask
   task automatic wait_write0(string n);
      for (int i = 0; i < 100 && !write0; i++) tick();
      chk(n, 64'(write0), 64'd1);
   endtask
   task automatic finish_rec0(string n);
      wait_empty0({n, "_drain"});
      stop0 = 1; tick(); stop0 = 0;
      for (int i = 0; i < 100 && !done0; i++) tick();
      chk({n, "_done"}, 64'(done0), 64'd1);
      chk({n, "_sb_empty"}, 64'(sb0.size()), 64'd0);
   endtask
   initial begin
      logic [59:0] cap;
      repeat (3) @(posedge clk);
      #2 rst = 0;
      tick();
      chk("reset_bus", {3'b0, write0, addr0, data0, be0}, 64'h0);
      chk("reset_status", {36'h0, rd0, busy0, done0, full0, words0}, 64'h0);
      // two full words
      for (int i = 1; i <= 8; i++) pb0(2'b10, 8'(i));
      ex0(24'd0, 32'h04030201, 4'hF);
      ex0(24'd1, 32'h08070605, 4'hF);
      pulse_start0();
      finish_rec0("t1");
      chk("t1_words", 64'(words0), 64'd2);
      chk("t1_memfull", 64'(full0), 64'd0);
      // invalid entries discarded
      pb0(2'b10, 8'h11); pb0(2'b00, 8'hEE); pb0(2'b10, 8'h12); pb0(2'b00, 8'hEE);
      pb0(2'b01, 8'hEE); pb0(2'b10, 8'h13); pb0(2'b10, 8'h14);
      ex0(24'd0, 32'h14131211, 4'hF);
      pulse_start0();
      finish_rec0("t2");
      chk("t2_words", 64'(words0), 64'd1);
      // sync byte mid-word
      for (int i = 1; i <= 6; i++) pb0(2'b10, 8'(i));
      pb0(2'b11, 8'h47); pb0(2'b10, 8'hAA); pb0(2'b10, 8'hBB); pb0(2'b10, 8'hCC);
      ex0(24'd0, 32'h04030201, 4'hF);
`ifdef TS_PKT_ALIGN_EN
      ex0(24'd1, 32'h00000605, 4'h3);
      ex0(24'd2, 32'hCCBBAA47, 4'hF);
`else
      ex0(24'd1, 32'hAA470605, 4'hF);
      ex0(24'd2, 32'h0000CCBB, 4'h3);
`endif
      pulse_start0();
      finish_rec0("t3");
      chk("t3_words", 64'(words0), 64'd3);
      // waitrequest stall for 10 cycles
      wait0 = 1;
      for (int i = 1; i <= 8; i++) pb0(2'b10, 8'(8'h30 + i));
      ex0(24'd0, 32'h34333231, 4'hF);
      ex0(24'd1, 32'h38373635, 4'hF);
      pulse_start0();
      wait_write0("t4_write_seen");
      cap = {addr0, data0, be0};
      chk("t4_first_word", {4'h0, cap}, {4'h0, 24'd0, 32'h34333231, 4'hF});
      for (int i = 0; i < 10; i++) begin
         chk("t4_stall_stable", {2'b0, write0, rd0, addr0, data0, be0}, {2'b0, 1'b1, 1'b0, cap});
         tick();
      end
      wait0 = 0;
      tick();
      chk("t4_accept_first_low", {16'h0, addr0, words0}, {16'h0, 24'd1, 24'd1});
      finish_rec0("t4");
      chk("t4_words", 64'(words0), 64'd2);
      // STOP flushes a partial word
      pb0(2'b10, 8'h21); pb0(2'b10, 8'h22); pb0(2'b10, 8'h23);
      ex0(24'd0, 32'h00232221, 4'h7);
      pulse_start0();
      finish_rec0("t5");
      chk("t5_words", 64'(words0), 64'd1);
      // asynchronous reset during a stalled write
      wait0 = 1;
      for (int i = 1; i <= 4; i++) pb0(2'b10, 8'(8'h50 + i));
      pulse_start0();
      wait_write0("t6_write_seen");
      tick();
      rst = 1;
      #1;
      chk("t6_reset_bus", {3'b0, write0, addr0, data0, be0}, 64'h0);
      chk("t6_reset_status", {36'h0, rd0, busy0, done0, full0, words0}, 64'h0);
      tick();
      rst = 0; wait0 = 0;
      q0.delete();
      tick();
      // memory end on the second instance
      for (int i = 1; i <= 12; i++) q1.push_back({2'b10, 8'(8'h60 + i)});
      sb1.push_back({24'hFFFFFE, 32'h64636261, 4'hF});
      sb1.push_back({24'hFFFFFF, 32'h68676665, 4'hF});
      tick();
      start1 = 1; tick(); start1 = 0;
      for (int i = 0; i < 100 && !done1; i++) tick();
      repeat (5) tick();
      chk("t7_done_full", {62'h0, done1, full1}, 64'h3);
      chk("t7_words", 64'(words1), 64'd2);
      chk("t7_fifo_left", 64'(q1.size()), 64'd4);
      chk("t7_sb_empty", 64'(sb1.size()), 64'd0);
      chk("t7_addr_nowrap", 64'(addr1), 64'hFFFFFF);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ts_ddr_write_packer.md
# ts_ddr_write_packer

Record-path packer between the input-side asynchronous FIFO (TS bytes crossing from the 6 MHz domain) and the DDR3 write port, all on the 50 MHz system clock. It pops 10-bit `{valid, sync, data}` entries, discards entries with valid low, and packs four TS bytes per 32-bit word. Each word is issued as an Avalon-MM style write at consecutive word addresses. With packet alignment compiled in, every TS packet (188 bytes) starts on a word boundary, so one packet occupies exactly 47 words.

## Interface
Parameters:
- `BASE_ADDR`, 24'h000000, first word address written after START.
- `LAST_ADDR`, 24'hFFFFFF, last usable word address; a write accepted here ends the recording.

Ports:
- `SYS_CLOCK` in 1: 50 MHz system clock; the only clock.
- `SYS_RESET` in 1: asynchronous, active-high reset.
- `START` in 1: one-cycle pulse; begins a recording at `BASE_ADDR`. Honoured only in IDLE or DONE.
- `STOP` in 1: one-cycle pulse; ends the recording after flushing any partial word.
- `fifo_q` in 10: FIFO head `{valid, sync, data[7:0]}`. The FIFO is show-ahead, so `fifo_q` is valid whenever `fifo_empty` is low.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rdreq` out 1: pops the head entry. Combinational.
- `ddr_write_address` out 24: word address.
- `ddr_write_write` out 1: write request.
- `ddr_write_writedata` out 32: packed bytes. The earliest byte goes in [7:0].
- `ddr_write_byteenable` out 4: lane enables.
- `ddr_write_waitrequest` in 1: a write is not accepted while this is high.
- `BUSY` out 1: high in FILL or WRITE.
- `DONE` out 1: high in DONE.
- `MEM_FULL` out 1: set when the write to `LAST_ADDR` is accepted; cleared by START.
- `WORDS_WRITTEN` out 24: count of accepted writes since START; saturates at 24'hFFFFFF.

## Operation
States: IDLE, FILL, WRITE, DONE.

- **Reset:** state is IDLE and every registered output is 0. This includes `ddr_write_byteenable` = 4'h0, `ddr_write_address` = 0, the lane counter and the stop-pending flag.
- **IDLE / DONE:**
  - `fifo_rdreq` = 0.
  - START loads address = `BASE_ADDR`, lane = 0, `WORDS_WRITTEN` = 0, clears `MEM_FULL`, and moves to FILL.
- **FILL:** `fifo_rdreq` = !fifo_empty && !align_hold.
  - A popped entry with valid = 0 is discarded and the lane is unchanged.
  - A popped entry with valid = 1 writes data into byte lane `lane`, sets the enable bit for `lane`, and does lane <= lane + 1 (2-bit).
  - When the byte lands in lane 3, load the output word with byteenable 4'hF and go to WRITE.
- **align_hold** (macro on only): `fifo_q` valid = 1 and sync = 1 and lane != 0 and !fifo_empty.
  - The entry is not popped.
  - The partial word goes to WRITE with the byteenable of the filled lanes (e.g. 4'h3 for 2 bytes). Unused lanes carry 8'h00.
  - Lane is reset to 0. The held sync entry is popped on return to FILL.
- **STOP in FILL:**
  - A byte popped in the same cycle is included.
  - If lane (after that byte) != 0, go to WRITE with the partial word and set stop-pending. Otherwise go to DONE.
- **WRITE:**
  - `ddr_write_write` = 1, with address, data and byteenable held stable.
  - On !waitrequest the write is accepted: `WORDS_WRITTEN`++ and the byteenable register clears.
  - Next state on acceptance, in priority order:
    - address == `LAST_ADDR`: set `MEM_FULL`, go to DONE. The address does not wrap.
    - else stop-pending: address++, go to DONE.
    - else: address++, go to FILL.
- **STOP in WRITE:** latched into stop-pending and acted on at acceptance.
- **START outside IDLE/DONE:** ignored.
- **START and STOP in the same cycle in IDLE/DONE:** START wins.

## Timing
- `fifo_rdreq` is combinational from state, `fifo_empty` and `fifo_q`. A pop occurs on the same edge that registers the byte.
- Latency from the 4th valid byte popped to `ddr_write_write` high: 1 cycle.
- With waitrequest low, WRITE lasts 1 cycle. Minimum 5 cycles per full word, i.e. 40 MB/s sustained, which exceeds the 6 MB/s TS rate.
- No pops occur while in WRITE. The FIFO absorbs DDR stalls.
- A partial flush costs 1 WRITE cycle. The sync entry pops on the first FILL cycle afterwards.
- DONE is reached 1 cycle after the final acceptance (or after STOP with lane = 0).
- `SYS_RESET` mid-write drops `ddr_write_write` immediately (asynchronous). The in-flight word is lost.

## Configuration
- `TS_PKT_ALIGN_EN` defined: align_hold is active. Every sync byte starts a new word at lane 0.
- `TS_PKT_ALIGN_EN` undefined: the sync bit is ignored and the stream is packed contiguously. Partial words are produced only by STOP.

## Test plan
- START, then 8 valid bytes 0x01..0x08 with no sync and no waitrequest -> two writes: addr 0 data 0x04030201 BE 4'hF, addr 1 data 0x08070605 BE 4'hF; `WORDS_WRITTEN` = 2.
- Entries with valid = 0 interleaved between bytes 0x11..0x14 -> one write, 0x14131211; no extra pops are stalled.
- Macro on: 6 bytes, then a sync byte 0x47 followed by 0xAA 0xBB 0xCC. Expect:
  - addr 0: 0x04030201.
  - addr 1: 0x00000605, BE 4'h3.
  - addr 2: 0xCCBBAA47.
  - Macro off: the same stimulus packs contiguously.
- waitrequest held high for 10 cycles during a write -> `ddr_write_write`, address, data and BE stable throughout; no `fifo_rdreq`; accepted on the first low cycle.
- Memory end: `BASE_ADDR` = 24'hFFFFFE, `LAST_ADDR` = 24'hFFFFFF, 12 bytes supplied -> exactly 2 writes, then `MEM_FULL` = 1 and `DONE` = 1; remaining bytes stay in the FIFO.
- STOP after 3 bytes 0x21..0x23 -> one write with data 0x00232221 and BE 4'h7, then DONE. Asserting `SYS_RESET` mid-WRITE -> all outputs 0 immediately.
